// File: rtl/morningjava_pkg.sv
// Shared types and constants for the morningjava 7-segment display blocks.
package morningjava_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } seq_state_t;

    localparam logic [7:0]  SEG_BLANK  = 8'h00;
    localparam int unsigned SEG_DP_BIT = 7;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/morningjava_seg7.sv
// Hex nibble to 7-segment decoder with a registered output, {p,g,f,e,d,c,b,a}.
// The output register is intentionally not reset; the consumer masks it.
module morningjava_seg7 (
    input  logic       clk,
    input  logic [3:0] data_in,
    output logic [7:0] seg_out
);

    logic [7:0] pattern;

    // Combinational hex glyph lookup; decimal point bit is always clear here.
    always_comb begin
        pattern = 8'h00;
        unique case (data_in)
            4'h0: pattern = 8'h3F;
            4'h1: pattern = 8'h06;
            4'h2: pattern = 8'h5B;
            4'h3: pattern = 8'h4F;
            4'h4: pattern = 8'h66;
            4'h5: pattern = 8'h6D;
            4'h6: pattern = 8'h7D;
            4'h7: pattern = 8'h07;
            4'h8: pattern = 8'h7F;
            4'h9: pattern = 8'h6F;
            4'hA: pattern = 8'h77;
            4'hB: pattern = 8'h7C;
            4'hC: pattern = 8'h39;
            4'hD: pattern = 8'h5E;
            4'hE: pattern = 8'h79;
            4'hF: pattern = 8'h71;
            default: pattern = 8'h00;
        endcase
    end

    // Output register, one cycle of latency from data_in.
    always_ff @(posedge clk) begin
        seg_out <= pattern;
    end

endmodule

// File: rtl/morningjava_seg7_sequencer.sv
// Shows a multi-nibble hex value on one 7-segment digit, MSB nibble first,
// each nibble for DWELL_CYCLES followed by GAP_CYCLES of blank. The decimal
// point marks the last nibble.
module morningjava_seg7_sequencer
    import morningjava_pkg::*;
#(
    parameter int unsigned NIBBLES      = 4,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES   = 250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [4*NIBBLES-1:0]   data,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             segments
);

    localparam int unsigned    CNT_W      = $clog2(max_u(DWELL_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    // Only meaningful when a gap exists; the zero-gap path never loads it.
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [2:0]       IDX_LAST   = 3'(NIBBLES - 1);

    seq_state_t           state;
    logic [4*NIBBLES-1:0] data_q;
    logic [2:0]           idx;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           nib_q;
    logic                 blank_q;
    logic                 dp_q;
    logic                 blank_q_d;
    logic                 dp_q_d;

    logic [2:0]           idx_dn;
    logic [3:0]           nib_next;
    logic [7:0]           dec;
    logic                 unused_dec_dp;

    assign idx_dn        = idx - 3'd1;
    assign unused_dec_dp = dec[SEG_DP_BIT];

    // Select the nibble that follows the current one, using constant slices only.
    always_comb begin
        nib_next = 4'h0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx_dn == 3'(i)) begin
                nib_next = data_q[4*i +: 4];
            end
        end
    end

    // Sequencer FSM with registered busy/done and display controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            data_q  <= '0;
            idx     <= 3'd0;
            cnt     <= '0;
            nib_q   <= 4'h0;
            blank_q <= 1'b1;
            dp_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                busy    <= 1'b0;
                blank_q <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        blank_q <= 1'b1;
                        if (start) begin
                            state   <= SHOW;
                            busy    <= 1'b1;
                            data_q  <= data;
                            idx     <= IDX_LAST;
                            nib_q   <= data[4*(NIBBLES-1) +: 4];
                            cnt     <= DWELL_LOAD;
                            blank_q <= 1'b0;
                            dp_q    <= (IDX_LAST == 3'd0);
                        end
                    end
                    SHOW: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            cnt     <= GAP_LOAD;
                            blank_q <= 1'b1;
                        end else if (idx == 3'd0) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            blank_q <= 1'b1;
                        end else begin
                            idx     <= idx_dn;
                            nib_q   <= nib_next;
                            dp_q    <= (idx_dn == 3'd0);
                            cnt     <= DWELL_LOAD;
                        end
                    end
                    GAP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (idx == 3'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= SHOW;
                            idx     <= idx_dn;
                            nib_q   <= nib_next;
                            dp_q    <= (idx_dn == 3'd0);
                            blank_q <= 1'b0;
                            cnt     <= DWELL_LOAD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Delay blank/dp by one stage to line up with the decoder output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q_d <= 1'b1;
            dp_q_d    <= 1'b0;
        end else begin
            blank_q_d <= blank_q;
            dp_q_d    <= dp_q;
        end
    end

    morningjava_seg7 u_seg7 (
        .clk     (clk),
        .data_in (nib_q),
        .seg_out (dec)
    );

    // Board pins: blanking masks the unreset decoder register.
    always_comb begin
        segments = blank_q_d ? SEG_BLANK : {dp_q_d, dec[SEG_DP_BIT-1:0]};
    end

endmodule

// File: tb/tb_morningjava_seg7_sequencer.sv
// Scoreboard bench for morningjava_seg7_sequencer: two instances (gap 2 and
// gap 0) share stimulus; per-cycle expectations are queued per instance.
module tb_morningjava_seg7_sequencer;

    localparam int unsigned N = 4;
    localparam int unsigned D = 4;

    typedef struct packed {
        logic [7:0] seg;
        logic       busy;
        logic       done;
    } exp_t;
    typedef exp_t eq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] data = 16'h0;

    logic       busy_g2, done_g2, busy_g0, done_g0;
    logic [7:0] seg_g2, seg_g0;

    int n_checks = 0;
    int n_fail   = 0;

    eq_t  q2, q0;
    exp_t e2, e0;

    always #5 clk = ~clk;

    morningjava_seg7_sequencer #(
        .NIBBLES      (N),
        .DWELL_CYCLES (D),
        .GAP_CYCLES   (2)
    ) dut_g2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .data     (data),
        .busy     (busy_g2),
        .done     (done_g2),
        .segments (seg_g2)
    );

    morningjava_seg7_sequencer #(
        .NIBBLES      (N),
        .DWELL_CYCLES (D),
        .GAP_CYCLES   (0)
    ) dut_g0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .data     (data),
        .busy     (busy_g0),
        .done     (done_g0),
        .segments (seg_g0)
    );

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 8'h3F;
            4'h1: return 8'h06;
            4'h2: return 8'h5B;
            4'h3: return 8'h4F;
            4'h4: return 8'h66;
            4'h5: return 8'h6D;
            4'h6: return 8'h7D;
            4'h7: return 8'h07;
            4'h8: return 8'h7F;
            4'h9: return 8'h6F;
            4'hA: return 8'h77;
            4'hB: return 8'h7C;
            4'hC: return 8'h39;
            4'hD: return 8'h5E;
            4'hE: return 8'h79;
            default: return 8'h71;
        endcase
    endfunction

    // Expected outputs after each edge, starting with the edge that accepts start.
    function automatic eq_t build_msg(input int unsigned gap, input logic [15:0] d);
        eq_t         m;
        exp_t        e;
        int unsigned per, total, k, j, r;
        per   = D + gap;
        total = N * per;
        for (int unsigned t = 0; t <= total; t++) begin
            e.busy = (t < total);
            e.done = (t == total);
            e.seg  = 8'h00;
            if (t >= 1) begin
                k = t - 1;
                j = k / per;
                r = k % per;
                if (r < D) begin
                    e.seg = hex7(d[4*(N-1-j) +: 4]) | ((j == N - 1) ? 8'h80 : 8'h00);
                end
            end
            m.push_back(e);
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge given the inputs sampled at it.
    task automatic model_step(input logic st, input logic ab, input logic [15:0] d);
        exp_t e;
        if (ab) begin
            if (q2.size() != 0) begin
                e = q2[0]; e.busy = 1'b0; e.done = 1'b0;
                q2.delete(); q2.push_back(e);
            end
            if (q0.size() != 0) begin
                e = q0[0]; e.busy = 1'b0; e.done = 1'b0;
                q0.delete(); q0.push_back(e);
            end
        end else if (st) begin
            if (q2.size() == 0) q2 = build_msg(2, d);
            if (q0.size() == 0) q0 = build_msg(0, d);
        end
    endtask

    task automatic drive(input logic st, input logic ab, input logic [15:0] d);
        @(negedge clk);
        #1;
        start = st;
        abort = ab;
        data  = d;
        model_step(st, ab, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg_g2", seg_g2, 8'h00);
        check("async_rst_busy_g2", 8'(busy_g2), 8'h00);
        check("async_rst_seg_g0", seg_g0, 8'h00);
        check("async_rst_busy_g0", 8'(busy_g0), 8'h00);
        q2.delete();
        q0.delete();
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per edge, idle values when nothing is queued.
    always @(negedge clk) begin
        e2 = (q2.size() != 0) ? q2.pop_front() : '{seg: 8'h00, busy: 1'b0, done: 1'b0};
        e0 = (q0.size() != 0) ? q0.pop_front() : '{seg: 8'h00, busy: 1'b0, done: 1'b0};
        check("seg_g2", seg_g2, e2.seg);
        check("busy_g2", 8'(busy_g2), 8'(e2.busy));
        check("done_g2", 8'(done_g2), 8'(e2.done));
        check("seg_g0", seg_g0, e0.seg);
        check("busy_g0", 8'(busy_g0), 8'(e0.busy));
        check("done_g0", 8'(done_g0), 8'(e0.done));
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Normal message
        drive(1'b1, 1'b0, 16'h1A3F);
        idle(30);

        // Start while busy must be ignored
        drive(1'b1, 1'b0, 16'h1A3F);
        idle(4);
        drive(1'b1, 1'b0, 16'h0000);
        idle(30);

        // Abort during the third nibble, then start+abort together in idle
        drive(1'b1, 1'b0, 16'h1A3F);
        idle(13);
        drive(1'b0, 1'b1, 16'h0000);
        idle(5);
        drive(1'b1, 1'b1, 16'h5555);
        idle(5);

        // Asynchronous reset mid-SHOW, then restart
        drive(1'b1, 1'b0, 16'hBEEF);
        idle(2);
        async_reset();
        idle(2);

        // Restart in the cycle done is visible
        drive(1'b1, 1'b0, 16'hC0DE);
        idle(24);
        drive(1'b1, 1'b0, 16'h2468);
        idle(30);

        // Randomized traffic
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 400) == 0) begin
                async_reset();
            end else begin
                drive($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, 16'($urandom));
            end
        end
        idle(30);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
